serial_add_seq: RTL and testbench

Bit-serial add/subtract sequencer that time-multiplexes a single gate-level `addbit` full adder over a WIDTH-bit operand pair, LSB first. It sits between a requesting datapath and the shared `addbit` cell. It loads operands, runs one bit per clock with a registered carry, and returns sum, carry-out and signed overflow. Requests and responses each use a valid/ready handshake.

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/addbit.sv | 20 ++
 rtl/serial_add_seq.sv | 108 ++++++++++
 tb/tb_serial_add_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add/subtract sequencer and the datapaths that
// consume its results.
package serial_add_pkg;

  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH_MAX-1:0] sum;
    logic                 co;
    logic                 ovf;
  } add_rsp_t;

endpackage

// File: rtl/addbit.sv
// Gate-level full adder bit-slice, time-shared by the serial sequencer.
module addbit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ab_x;
  logic ab_a;
  logic c_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (s, ab_x, ci);
  and g_a0 (ab_a, a, b);
  and g_a1 (c_a, ab_x, ci);
  or  g_o0 (co, ab_a, c_a);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: one addbit slice, LSB first, registered carry,
// valid/ready handshakes on both the request and the response side.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RUN   | one operand bit per clock through addbit
// DONE  | result held on rsp_* until rsp_ready
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sub,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_co,
  output logic             rsp_ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_add_seq: WIDTH must be in 2..32");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [CW-1:0]    cnt;
  logic             sub_q;
  logic             carry;
  logic             b_in;
  logic             bit_s;
  logic             bit_co;

  // Subtract feeds ~b with the carry preloaded to 1.
  assign b_in = b_sr[0] ^ sub_q;

  addbit u_addbit (
    .a  (a_sr[0]),
    .b  (b_in),
    .ci (carry),
    .s  (bit_s),
    .co (bit_co)
  );

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_sum   = sum_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      cnt       <= '0;
      sub_q     <= 1'b0;
      carry     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_co    <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_sr  <= req_a;
            b_sr  <= req_b;
            sub_q <= req_sub;
            carry <= req_sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
          carry  <= bit_co;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            // carry still holds the carry into the MSB on this last bit
            rsp_co    <= bit_co;
            rsp_ovf   <= carry ^ bit_co;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: arithmetic reference model, per-cycle
// output checker, directed corner cases, backpressure, mid-run reset and random traffic.
module tb_serial_add_seq;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_sub = 1'b0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_sum;
  logic         rsp_co;
  logic         rsp_ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_count = 0;
  int hs_count = 0;
  int acc_edge = 0;
  int hs_edge = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_co = 1'b0;
  logic         last_ovf = 1'b0;

  typedef struct {
    add_rsp_t r;
    int       acc;
  } pend_t;
  pend_t pend[$];

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sub   (req_sub),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_co    (rsp_co),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain integer arithmetic: unsigned result mod 2^W, carry/no-borrow, signed range overflow.
  function automatic add_rsp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic sub);
    add_rsp_t r;
    longint ua, ub, sa, sb, res, exact;
    longint modv;
    modv = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - modv : ua;
    sb = b[W-1] ? ub - modv : ub;
    r = '0;
    if (sub) begin
      res   = ua - ub;
      r.co  = (ua >= ub);
      exact = sa - sb;
    end else begin
      res   = ua + ub;
      r.co  = (res >= modv);
      exact = sa + sb;
    end
    r.sum = 32'(res & (modv - 1));
    r.ovf = (exact > (modv / 2 - 1)) || (exact < -(modv / 2));
    return r;
  endfunction

  // Edge monitor: records accepts and response handshakes, feeds the model queue.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pend.delete();
      end else begin
        if (req_valid && req_ready) begin
          pend.push_back('{model(req_a, req_b, req_sub), cyc});
          acc_count++;
          acc_edge = cyc;
        end
        if (rsp_valid && rsp_ready) begin
          last_sum = rsp_sum;
          last_co  = rsp_co;
          last_ovf = rsp_ovf;
          hs_count++;
          hs_edge = cyc;
          if (pend.size() != 0) void'(pend.pop_front());
        end
      end
    end
  end

  // Per-cycle output checker, sampled on the falling edge.
  initial begin
    logic exp_v;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_co", rsp_co, 0);
        chk("rst_rsp_ovf", rsp_ovf, 0);
      end else begin
        exp_v = (pend.size() != 0) && (cyc >= pend[0].acc + W);
        chk("req_ready", req_ready, pend.size() == 0);
        chk("rsp_valid", rsp_valid, exp_v);
        if (exp_v && rsp_valid) begin
          chk("rsp_sum", rsp_sum, pend[0].r.sum[W-1:0]);
          chk("rsp_co", rsp_co, pend[0].r.co);
          chk("rsp_ovf", rsp_ovf, pend[0].r.ovf);
        end
      end
    end
  end

  task automatic wait_accept(input string name);
    int n;
    logic got;
    n = acc_count;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc_count != n) got = 1'b1;
    end
    chk({name, "_accept_seen"}, got, 1);
  endtask

  task automatic wait_hs(input string name);
    int n;
    logic got;
    n = hs_count;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      #1;
      if (hs_count != n) got = 1'b1;
    end
    chk({name, "_response_seen"}, got, 1);
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] es, input logic eco,
                          input logic eovf);
    add_rsp_t m;
    m = model(a, b, sub);
    chk({name, "_model_sum"}, m.sum, es);
    chk({name, "_model_co"}, m.co, eco);
    chk({name, "_model_ovf"}, m.ovf, eovf);
    req_a = a;
    req_b = b;
    req_sub = sub;
    req_valid = 1'b1;
    wait_accept(name);
    req_valid = 1'b0;
    wait_hs(name);
    chk({name, "_sum"}, last_sum, es);
    chk({name, "_co"}, last_co, eco);
    chk({name, "_ovf"}, last_ovf, eovf);
    // handshake edge follows the first rsp_valid cycle, i.e. accept + W + 1
    chk({name, "_latency"}, hs_edge - acc_edge, W + 1);
  endtask

  initial begin
    int n;
    int prev;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", req_ready, 1);
    @(posedge clk);
    #1;

    directed("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    directed("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    directed("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    directed("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Backpressure with a second request pending the whole time.
    rsp_ready = 1'b0;
    req_a = 8'h33;
    req_b = 8'h44;
    req_sub = 1'b0;
    req_valid = 1'b1;
    wait_accept("bp");
    req_a = 8'h12;
    req_b = 8'h34;
    req_sub = 1'b1;
    n = acc_count;
    repeat (W + 5) @(posedge clk);
    #1;
    chk("bp_no_accept", acc_count, n);
    chk("bp_held_valid", rsp_valid, 1);
    chk("bp_held_sum", rsp_sum, 8'h77);
    rsp_ready = 1'b1;
    wait_accept("bp_next");
    chk("bp_next_gap", acc_edge - hs_edge, 1);
    req_valid = 1'b0;
    wait_hs("bp_next");
    chk("bp_next_sum", last_sum, 8'hDE);

    // Reset in the middle of a run.
    req_a = 8'hFF;
    req_b = 8'h00;
    req_sub = 1'b0;
    req_valid = 1'b1;
    wait_accept("rst_op");
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_sum", rsp_sum, 0);
    chk("midrst_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", req_ready, 1);
    directed("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Back-to-back random traffic.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      req_a = 8'($urandom());
      req_b = 8'($urandom());
      req_sub = 1'($urandom());
      wait_accept("rand");
      if (i > 0) chk("rand_interval", acc_edge - prev, W + 2);
      prev = acc_edge;
    end
    req_valid = 1'b0;
    wait_hs("rand_last");
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
